// File: rtl/checked_adder_ctrl.sv
// Sequencing and checking controller for a duplicated, parity-predicted adder.
// Registers operands, samples the adder after a settle window, retries failed checks, returns sum + status.
module checked_adder_ctrl #(
    parameter int W             = 64,
    parameter int SETTLE_CYCLES = 1,
    parameter int MAX_RETRY     = 2,
    parameter int FCNT_W        = 16,
    localparam int RW           = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [W-1:0]      req_a,
    input  logic [W-1:0]      req_b,
    input  logic              req_pa,
    input  logic              req_pb,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    output logic              add_pa,
    output logic              add_pb,
    input  logic [W-1:0]      add_s,
    input  logic [W-1:0]      add_s_dup,
    input  logic              add_papb,
    input  logic              add_pab,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [W-1:0]      resp_sum,
    output logic              resp_err,
    output logic [1:0]        resp_code,
    output logic [RW-1:0]     resp_retries,
    output logic [FCNT_W-1:0] fault_cnt,
    output logic [1:0]        o_dbg_state
);

    localparam int SW = $clog2(SETTLE_CYCLES + 2);
    // The first window is one cycle longer: the operands are only on the adder inputs
    // from the accept edge onward, so a fresh operation needs an extra cycle to settle.
    localparam logic [SW-1:0] SETTLE_FIRST  = SW'(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_RELOAD = SW'(SETTLE_CYCLES);
    localparam logic [SW-1:0] SETTLE_LAST   = SW'(1);
    localparam logic [RW-1:0] RETRY_LIMIT   = RW'(MAX_RETRY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SW-1:0]     r_settle;
    logic [RW-1:0]     r_retry;
    logic              r_req_ready;
    logic [W-1:0]      r_add_a;
    logic [W-1:0]      r_add_b;
    logic              r_add_pa;
    logic              r_add_pb;
    logic [W-1:0]      r_resp_sum;
    logic              r_resp_err;
    logic [1:0]        r_resp_code;
    logic [RW-1:0]     r_resp_retries;
    logic [FCNT_W-1:0] r_fault_cnt;

    logic w_accept;
    logic w_sample;
    logic w_retry;
    logic w_finish;
    logic w_dup_err;
    logic w_par_err;
    logic w_fail;

    assign w_dup_err = (add_s != add_s_dup);
    assign w_par_err = (add_pab != add_papb);
    assign w_fail    = w_dup_err | w_par_err;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_sample    = 1'b0;
        w_retry     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_settle == SETTLE_LAST) begin
                    w_sample = 1'b1;
                    if (w_fail && (r_retry < RETRY_LIMIT)) begin
                        w_retry = 1'b1;
                    end else begin
                        w_finish    = 1'b1;
                        w_state_nxt = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_req_ready    <= 1'b0;
            r_settle       <= '0;
            r_retry        <= '0;
            r_add_a        <= '0;
            r_add_b        <= '0;
            r_add_pa       <= 1'b0;
            r_add_pb       <= 1'b0;
            r_resp_sum     <= '0;
            r_resp_err     <= 1'b0;
            r_resp_code    <= '0;
            r_resp_retries <= '0;
            r_fault_cnt    <= '0;
        end else begin
            r_req_ready <= (w_state_nxt == ST_IDLE);
            if (w_accept) begin
                r_add_a  <= req_a;
                r_add_b  <= req_b;
                r_add_pa <= req_pa;
                r_add_pb <= req_pb;
                r_retry  <= '0;
                r_settle <= SETTLE_FIRST;
            end else if (r_state == ST_WAIT) begin
                if (w_retry) begin
                    r_settle <= SETTLE_RELOAD;
                    r_retry  <= r_retry + RW'(1);
                end else if (!w_sample) begin
                    r_settle <= r_settle - SW'(1);
                end
            end
            if (w_sample && w_fail && (r_fault_cnt != '1)) begin
                r_fault_cnt <= r_fault_cnt + FCNT_W'(1);
            end
            // On a pass both error flags are zero, so the code field needs no special case.
            if (w_finish) begin
                r_resp_sum     <= add_s;
                r_resp_err     <= w_fail;
                r_resp_code    <= {w_par_err, w_dup_err};
                r_resp_retries <= r_retry;
            end
        end
    end

    assign req_ready    = r_req_ready;
    assign add_a        = r_add_a;
    assign add_b        = r_add_b;
    assign add_pa       = r_add_pa;
    assign add_pb       = r_add_pb;
    assign resp_valid   = (r_state == ST_RESP);
    assign resp_sum     = r_resp_sum;
    assign resp_err     = r_resp_err;
    assign resp_code    = r_resp_code;
    assign resp_retries = r_resp_retries;
    assign fault_cnt    = r_fault_cnt;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_checked_adder_ctrl.sv
// Bench for checked_adder_ctrl: behavioural adder with dup-fault injection, directed cases,
// then randomized operations scored against an attempt-level reference model.
module tb_checked_adder_ctrl;

    localparam int W         = 64;
    localparam int S         = 1;
    localparam int MAX_RETRY = 2;
    localparam int FCNT_W    = 4;
    localparam int RW        = 2;
    localparam int FCNT_MAX  = (1 << FCNT_W) - 1;

    logic              clk = 1'b0;
    logic              nrst;
    logic              req_valid;
    logic              req_ready;
    logic [W-1:0]      req_a;
    logic [W-1:0]      req_b;
    logic              req_pa;
    logic              req_pb;
    logic [W-1:0]      add_a;
    logic [W-1:0]      add_b;
    logic              add_pa;
    logic              add_pb;
    logic [W-1:0]      add_s;
    logic [W-1:0]      add_s_dup;
    logic              add_papb;
    logic              add_pab;
    logic              resp_valid;
    logic              resp_ready;
    logic [W-1:0]      resp_sum;
    logic              resp_err;
    logic [1:0]        resp_code;
    logic [RW-1:0]     resp_retries;
    logic [FCNT_W-1:0] fault_cnt;
    logic [1:0]        dbg_state;

    logic              inj_dup;
    int                n_checks = 0;
    int                n_pass   = 0;
    int                n_fail   = 0;
    int                exp_fcnt = 0;
    logic [W-1:0]      exp_q[$];

    checked_adder_ctrl #(
        .W             (W),
        .SETTLE_CYCLES (S),
        .MAX_RETRY     (MAX_RETRY),
        .FCNT_W        (FCNT_W)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_pa       (req_pa),
        .req_pb       (req_pb),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_pa       (add_pa),
        .add_pb       (add_pb),
        .add_s        (add_s),
        .add_s_dup    (add_s_dup),
        .add_papb     (add_papb),
        .add_pab      (add_pab),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_sum     (resp_sum),
        .resp_err     (resp_err),
        .resp_code    (resp_code),
        .resp_retries (resp_retries),
        .fault_cnt    (fault_cnt),
        .o_dbg_state  (dbg_state)
    );

    // Fault-free adder; inj_dup flips bit 0 of the duplicate sum.
    assign add_s     = add_a + add_b;
    assign add_s_dup = add_s ^ {{(W-1){1'b0}}, inj_dup};
    assign add_papb  = add_pa ^ add_pb;
    assign add_pab   = ^(add_a ^ add_b);

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_req_ready"},    64'(req_ready),    64'd0);
        check({pfx, "_resp_valid"},   64'(resp_valid),   64'd0);
        check({pfx, "_resp_sum"},     resp_sum,          64'd0);
        check({pfx, "_resp_err"},     64'(resp_err),     64'd0);
        check({pfx, "_resp_code"},    64'(resp_code),    64'd0);
        check({pfx, "_resp_retries"}, 64'(resp_retries), 64'd0);
        check({pfx, "_fault_cnt"},    64'(fault_cnt),    64'd0);
        check({pfx, "_add_a"},        add_a,             64'd0);
        check({pfx, "_add_b"},        add_b,             64'd0);
        check({pfx, "_add_pa"},       64'(add_pa),       64'd0);
        check({pfx, "_add_pb"},       64'(add_pb),       64'd0);
    endtask

    // Issue one request; the first n_dup attempts see a duplicate-sum fault; the
    // response is held back for 'hold' cycles before it is accepted.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic pa, input logic pb, input int n_dup, input int hold);
        logic       par_bad;
        logic       e_err;
        logic [1:0] e_code;
        logic [W-1:0] e_sum;
        int         first_pass;
        int         e_retries;
        int         fails;
        int         e_lat;
        int         k;

        par_bad    = ((pa ^ pb) != (^(a ^ b)));
        first_pass = -1;
        for (int i = 0; i <= MAX_RETRY; i++) begin
            if (!(par_bad || (i < n_dup))) begin
                first_pass = i;
                break;
            end
        end
        if (first_pass >= 0) begin
            e_retries = first_pass;
            fails     = first_pass;
            e_err     = 1'b0;
            e_code    = 2'b00;
        end else begin
            e_retries = MAX_RETRY;
            fails     = MAX_RETRY + 1;
            e_err     = 1'b1;
            e_code    = {par_bad, (n_dup > MAX_RETRY)};
        end
        e_lat    = S + 1 + e_retries * S;
        exp_fcnt = (exp_fcnt + fails > FCNT_MAX) ? FCNT_MAX : exp_fcnt + fails;
        exp_q.push_back(a + b);

        @(negedge clk);
        req_a     = a;
        req_b     = b;
        req_pa    = pa;
        req_pb    = pb;
        req_valid = 1'b1;
        k = 0;
        while (req_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("accept_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        req_a     = {$urandom, $urandom};
        req_b     = {$urandom, $urandom};
        check("wait_req_ready", 64'(req_ready), 64'd0);
        check("add_a", add_a, a);
        check("add_b", add_b, b);
        check("add_pa", 64'(add_pa), 64'(pa));

        k = 0;
        while (k < 40) begin
            if (resp_valid === 1'b1) break;
            inj_dup = (k >= S) && ((k % S) == 0) && ((k / S - 1) < n_dup);
            @(negedge clk);
            k++;
        end
        inj_dup = 1'b0;
        check("latency", 64'(k), 64'(e_lat));

        e_sum = exp_q.pop_front();
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge clk);
            check("resp_valid",   64'(resp_valid),   64'd1);
            check("resp_sum",     resp_sum,          e_sum);
            check("resp_err",     64'(resp_err),     64'(e_err));
            check("resp_code",    64'(resp_code),    64'(e_code));
            check("resp_retries", 64'(resp_retries), 64'(e_retries));
            check("fault_cnt",    64'(fault_cnt),    64'(exp_fcnt));
            check("resp_req_ready", 64'(req_ready),  64'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("hs_resp_valid", 64'(resp_valid), 64'd0);
        check("hs_req_ready",  64'(req_ready),  64'd1);
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         pa;
        logic         pb;
        int           nd;
        int           sel;
        int           seen;

        nrst       = 1'b0;
        req_valid  = 1'b0;
        req_a      = '0;
        req_b      = '0;
        req_pa     = 1'b0;
        req_pb     = 1'b0;
        resp_ready = 1'b0;
        inj_dup    = 1'b0;
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
        check("rel_req_ready_low", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("rel_req_ready_high", 64'(req_ready), 64'd1);

        // Directed cases
        run_op(64'd1, 64'd2, 1'b1, 1'b1, 0, 0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 0, 0);
        run_op(64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F,
               ^64'h1234_5678_9ABC_DEF0, ^64'h0F0F_0F0F_0F0F_0F0F, 1, 0);
        run_op(64'd3, 64'd0, 1'b1, 1'b0, 0, 0);
        run_op(64'd100, 64'd200, ^64'd100, ^64'd200, 0, 5);
        run_op(64'd7, 64'd9, ^64'd7, ^64'd9, 3, 1);

        // Reset in the middle of WAIT drops the operation
        @(negedge clk);
        req_a     = 64'd5;
        req_b     = 64'd7;
        req_pa    = ^64'd5;
        req_pb    = ^64'd7;
        req_valid = 1'b1;
        seen = 0;
        while (req_ready !== 1'b1 && seen < 20) begin
            @(negedge clk);
            seen++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        #2 nrst = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        exp_fcnt = 0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) seen++;
        end
        check("lost_req_no_resp", 64'(seen), 64'd0);
        run_op(64'd11, 64'd22, ^64'd11, ^64'd22, 0, 0);

        // Randomized operations; the fault counter saturates along the way
        for (int n = 0; n < 24; n++) begin
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            pa  = ^a;
            pb  = ^b;
            sel = $urandom_range(0, 3);
            if (sel == 0) pa = ~pa;
            else if (sel == 1) pb = ~pb;
            nd = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) nd = 0;
            run_op(a, b, pa, pb, nd, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
